// File: rtl/redun_mont_pkg.sv
`default_nettype none
// redun_mont_pkg: multiplier ctl encoding, sequencer state encoding and limb types
// shared by the redundant-form Montgomery squaring sequencer.
package redun_mont_pkg;

  localparam int DEF_NUM_ELEMENTS = 33;
  localparam int DEF_DSP_BIT_LEN  = 17;

  localparam logic [1:0] CTL_LO = 2'd0;
  localparam logic [1:0] CTL_HI = 2'd1;
  localparam logic [1:0] CTL_SQ = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISS_SQ = 3'd1,
    WT_SQ  = 3'd2,
    ISS_LO = 3'd3,
    WT_LO  = 3'd4,
    ISS_HI = 3'd5,
    WT_HI  = 3'd6,
    DONE   = 3'd7
  } seq_state_t;

  typedef logic [DEF_DSP_BIT_LEN-1:0] limb_t;
  typedef limb_t [DEF_NUM_ELEMENTS-1:0] limb_arr_t;

endpackage
`default_nettype wire

// File: rtl/redun_mont_sq_sequencer.sv
`default_nettype none
// redun_mont_sq_sequencer: drives one multi-mode multiplier through square / low / high
// Montgomery steps per iteration. REDUN_MONT_SEQ_CYCLE_CNT_EN builds the busy-cycle counter.
module redun_mont_sq_sequencer
  import redun_mont_pkg::*;
#(
  parameter int NUM_ELEMENTS = 33,
  parameter int DSP_BIT_LEN  = 17,
  parameter int ITER_W       = 32
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic                                    i_start,
  output logic                                    o_ready,
  input  logic [ITER_W-1:0]                       i_iter,
  input  logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]     i_x,
  input  logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]     i_m,
  input  logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]     i_mprime,
  output logic                                    o_mul_val,
  output logic [1:0]                              o_mul_ctl,
  output logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]     o_mul_a,
  output logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]     o_mul_b,
  output logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]     o_mul_add,
  input  logic                                    i_mul_val,
  input  logic [2*NUM_ELEMENTS*DSP_BIT_LEN-1:0]   i_mul_dat,
  output logic                                    o_val,
  input  logic                                    i_rdy,
  output logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]     o_x,
  output logic                                    o_err,
  output logic [31:0]                             o_cycle_cnt
);

  localparam int W = NUM_ELEMENTS * DSP_BIT_LEN;

  seq_state_t        state;
  seq_state_t        state_nx;
  logic [W-1:0]      x_reg;
  logic [W-1:0]      th_reg;
  logic [ITER_W-1:0] cnt;
  logic              err_reg;

  // The a-operand register doubles as the TL and Q holding registers: TL is
  // only ever consumed as the low-multiply operand, Q only as the high one.
  logic              issue_reg;
  logic [1:0]        ctl_reg;
  logic [W-1:0]      a_reg;
  logic [W-1:0]      b_reg;
  logic [W-1:0]      add_reg;

  logic              issue_nx;
  logic [1:0]        ctl_nx;
  logic [W-1:0]      a_nx;
  logic [W-1:0]      b_nx;
  logic [W-1:0]      add_nx;

  logic [W-1:0]      dat_lo;
  logic [W-1:0]      dat_hi;
  logic              in_wait;
  logic              start_acc;

  assign dat_lo    = i_mul_dat[W-1:0];
  assign dat_hi    = i_mul_dat[2*W-1:W];
  assign in_wait   = (state == WT_SQ) || (state == WT_LO) || (state == WT_HI);
  assign start_acc = (state == IDLE) && i_start;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_start) state_nx = (i_iter == '0) ? DONE : ISS_SQ;
      ISS_SQ:  state_nx = WT_SQ;
      WT_SQ:   if (i_mul_val) state_nx = ISS_LO;
      ISS_LO:  state_nx = WT_LO;
      WT_LO:   if (i_mul_val) state_nx = ISS_HI;
      ISS_HI:  state_nx = WT_HI;
      WT_HI:   if (i_mul_val) state_nx = (cnt == ITER_W'(1)) ? DONE : ISS_SQ;
      DONE:    if (i_rdy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Issue outputs are computed for the state being entered so they are
  // already registered during the ISS_* cycle and held until the next issue.
  always_comb begin
    issue_nx = 1'b0;
    ctl_nx   = ctl_reg;
    a_nx     = a_reg;
    b_nx     = b_reg;
    add_nx   = add_reg;
    case (state_nx)
      ISS_SQ: begin
        issue_nx = 1'b1;
        ctl_nx   = CTL_SQ;
        a_nx     = (state == IDLE) ? i_x : dat_hi;
        b_nx     = (state == IDLE) ? i_x : dat_hi;
        add_nx   = '0;
      end
      ISS_LO: begin
        issue_nx = 1'b1;
        ctl_nx   = CTL_LO;
        a_nx     = dat_lo;
        b_nx     = i_mprime;
        add_nx   = '0;
      end
      ISS_HI: begin
        issue_nx = 1'b1;
        ctl_nx   = CTL_HI;
        a_nx     = dat_lo;
        b_nx     = i_m;
        add_nx   = th_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      issue_reg <= 1'b0;
      ctl_reg   <= CTL_SQ;
      a_reg     <= '0;
      b_reg     <= '0;
      add_reg   <= '0;
    end else begin
      issue_reg <= issue_nx;
      ctl_reg   <= ctl_nx;
      a_reg     <= a_nx;
      b_reg     <= b_nx;
      add_reg   <= add_nx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_reg   <= '0;
      th_reg  <= '0;
      cnt     <= '0;
      err_reg <= 1'b0;
    end else begin
      if (start_acc) begin
        x_reg <= i_x;
        cnt   <= i_iter;
      end
      if ((state == WT_SQ) && i_mul_val) begin
        th_reg <= dat_hi;
      end
      if ((state == WT_HI) && i_mul_val) begin
        x_reg <= dat_hi;
        cnt   <= cnt - ITER_W'(1);
      end
      if (i_mul_val && !in_wait) begin
        err_reg <= 1'b1;
      end
    end
  end

`ifdef REDUN_MONT_SEQ_CYCLE_CNT_EN
  logic [31:0] cyc_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cyc_cnt <= '0;
    end else if (start_acc) begin
      cyc_cnt <= '0;
    end else if ((state != IDLE) && (state != DONE) && (cyc_cnt != 32'hFFFF_FFFF)) begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end

  assign o_cycle_cnt = cyc_cnt;
`else
  assign o_cycle_cnt = 32'd0;
`endif

  assign o_ready   = (state == IDLE);
  assign o_val     = (state == DONE);
  assign o_x       = x_reg;
  assign o_err     = err_reg;
  assign o_mul_val = issue_reg;
  assign o_mul_ctl = ctl_reg;
  assign o_mul_a   = a_reg;
  assign o_mul_b   = b_reg;
  assign o_mul_add = add_reg;

endmodule
`default_nettype wire

// File: tb/tb_redun_mont_sq_sequencer.sv
`default_nettype none
// tb_redun_mont_sq_sequencer: directed bench with a fixed-latency multiplier model
// and a software Montgomery-square reference.
module tb_redun_mont_sq_sequencer;

  localparam int N = 33;
  localparam int D = 17;
  localparam int W = N * D;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           ready;
  logic [31:0]    iter;
  logic [W-1:0]   x_in;
  logic [W-1:0]   m;
  logic [W-1:0]   mp;
  logic           mul_val_o;
  logic [1:0]     ctl;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [W-1:0]   op_add;
  logic           mul_val_i;
  logic [2*W-1:0] mul_dat;
  logic           val;
  logic           rdy;
  logic [W-1:0]   xo;
  logic           err;
  logic [31:0]    cyc;
  logic           inj_val;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  redun_mont_sq_sequencer dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_ready(ready), .i_iter(iter),
    .i_x(x_in), .i_m(m), .i_mprime(mp), .o_mul_val(mul_val_o), .o_mul_ctl(ctl),
    .o_mul_a(op_a), .o_mul_b(op_b), .o_mul_add(op_add), .i_mul_val(mul_val_i),
    .i_mul_dat(mul_dat), .o_val(val), .i_rdy(rdy), .o_x(xo), .o_err(err),
    .o_cycle_cnt(cyc)
  );

  function automatic logic [2*W-1:0] mul2(input logic [W-1:0] p, input logic [W-1:0] q);
    logic [2*W-1:0] pe;
    logic [2*W-1:0] qe;
    pe = {{W{1'b0}}, p};
    qe = {{W{1'b0}}, q};
    return pe * qe;
  endfunction

  // Multiplier model: product after L cycles; high mode returns T + Q*M exactly,
  // using the TL it saw as the last low-mode a operand.
  logic [L-1:0]   pv;
  logic [2*W-1:0] pd [L];
  logic [W-1:0]   lo_a;
  int             ctl_log[$];

  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv <= {pv[L-2:0], mul_val_o};
      if (mul_val_o) begin
        ctl_log.push_back(int'(ctl));
        if (ctl == 2'd1) pd[0] <= mul2(op_a, op_b) + {op_add, {W{1'b0}}} + {{W{1'b0}}, lo_a};
        else             pd[0] <= mul2(op_a, op_b);
        if (ctl == 2'd0) lo_a <= op_a;
      end
      for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
    end
  end

  assign mul_val_i = pv[L-1] | inj_val;
  assign mul_dat   = pd[L-1];

  function automatic logic [W-1:0] neg_inv(input logic [W-1:0] mm);
    logic [W-1:0] inv;
    inv = mm;
    for (int i = 0; i < 10; i++) inv = inv * (W'(2) - mm * inv);
    return W'(0) - inv;
  endfunction

  function automatic logic [W-1:0] mont_ref(input logic [W-1:0] xx, input logic [W-1:0] mm,
                                            input logic [W-1:0] mpp);
    logic [2*W-1:0] t;
    logic [2*W-1:0] qf;
    logic [2*W-1:0] s;
    t  = mul2(xx, xx);
    qf = mul2(t[W-1:0], mpp);
    s  = t + mul2(qf[W-1:0], mm);
    return s[2*W-1:W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [31:0] n, input logic [W-1:0] xv, output int cycles);
    start  = 1'b1;
    iter   = n;
    x_in   = xv;
    tick();
    start  = 1'b0;
    cycles = 1;
    while (!val && cycles < 3000) begin
      tick();
      cycles++;
    end
  endtask

  task automatic chk_ctl(input string tag, input int base, input int n_issue);
    int pat[3];
    pat = '{2, 0, 1};
    chk({tag, "_issues"}, W'(ctl_log.size() - base), W'(n_issue));
    for (int k = base; k < ctl_log.size(); k++)
      chk({tag, "_ctl"}, W'(ctl_log[k]), W'(pat[(k - base) % 3]));
  endtask

  task automatic accept();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("accept_val", W'(val), W'(0));
    chk("accept_ready", W'(ready), W'(1));
  endtask

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) v[i*D +: D] = D'($urandom_range(0, (1 << D) - 1));
    return v;
  endfunction

  logic [W-1:0]   exp_x;
  logic [W-1:0]   hold_x;
  logic [2*W-1:0] wide_a;
  logic [2*W-1:0] wide_m;
  logic [31:0]    exp_cyc;
  int             cycles;
  int             base;
  int             guard;

  initial begin
    rst = 1'b1; start = 1'b0; iter = '0; x_in = '0; rdy = 1'b0; inj_val = 1'b0;
    m = W'(7);
    mp = neg_inv(W'(7));
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", W'(ready), W'(1));
    chk("rst_val", W'(val), W'(0));
    chk("rst_mul_val", W'(mul_val_o), W'(0));
    chk("rst_ctl", W'(ctl), W'(2));
    chk("rst_err", W'(err), W'(0));
    chk("rst_cyc", W'(cyc), W'(0));
    chk("rst_x", xo, W'(0));
    chk("mprime_inv", W'(m * mp + W'(1)), W'(0));

    // zero iterations: straight to DONE with the input value
    base = ctl_log.size();
    run(32'd0, W'(5), cycles);
    chk("it0_latency", W'(cycles), W'(1));
    chk("it0_x", xo, W'(5));
    chk("it0_issues", W'(ctl_log.size() - base), W'(0));
    accept();

    // single iteration, M=7, x=3
    base  = ctl_log.size();
    exp_x = mont_ref(W'(3), m, mp);
    run(32'd1, W'(3), cycles);
    chk("it1_latency", W'(cycles), W'(16));
    chk("it1_x", xo, exp_x);
    wide_a = {xo, {W{1'b0}}};
    wide_m = {{W{1'b0}}, m};
    chk("it1_congruent", W'(wide_a % wide_m), W'(2));
`ifdef REDUN_MONT_SEQ_CYCLE_CNT_EN
    exp_cyc = 32'd15;
`else
    exp_cyc = 32'd0;
`endif
    chk("it1_cyc", W'(cyc), W'(exp_cyc));
    chk_ctl("it1", base, 3);

    // DONE hold with i_rdy low and stray starts
    hold_x = exp_x;
    base   = ctl_log.size();
    for (int i = 0; i < 20; i++) begin
      start = i[0];
      iter  = 32'd5;
      x_in  = W'(9);
      tick();
      chk("hold_val", W'(val), W'(1));
      chk("hold_x", xo, hold_x);
      chk("hold_ready", W'(ready), W'(0));
    end
    start = 1'b0;
    chk("hold_issues", W'(ctl_log.size() - base), W'(0));
    accept();

    // ten iterations on a random 561-bit odd modulus below R/4
    m = rand_wide();
    m[0] = 1'b1;
    m[W-1] = 1'b0;
    m[W-2] = 1'b0;
    mp = neg_inv(m);
    wide_a = {{W{1'b0}}, rand_wide()};
    wide_m = {{W{1'b0}}, m};
    wide_a = wide_a % wide_m;
    exp_x = wide_a[W-1:0];
    hold_x = exp_x;
    for (int i = 0; i < 10; i++) exp_x = mont_ref(exp_x, m, mp);
    base = ctl_log.size();
    run(32'd10, hold_x, cycles);
    chk("it10_latency", W'(cycles), W'(151));
    chk("it10_x", xo, exp_x);
`ifdef REDUN_MONT_SEQ_CYCLE_CNT_EN
    exp_cyc = 32'd150;
`else
    exp_cyc = 32'd0;
`endif
    chk("it10_cyc", W'(cyc), W'(exp_cyc));
    chk_ctl("it10", base, 30);
    accept();

    // stray multiplier valid while idle
    inj_val = 1'b1;
    tick();
    inj_val = 1'b0;
    chk("inj_err", W'(err), W'(1));
    tick();
    tick();
    tick();
    chk("inj_err_sticky", W'(err), W'(1));
    hold_x = W'(12345);
    exp_x  = mont_ref(mont_ref(hold_x, m, mp), m, mp);
    base   = ctl_log.size();
    run(32'd2, hold_x, cycles);
    chk("inj_run_x", xo, exp_x);
    chk("inj_run_err", W'(err), W'(1));
    chk_ctl("inj_run", base, 6);
    accept();

    // reset while waiting on the low multiply
    base  = ctl_log.size();
    start = 1'b1;
    iter  = 32'd3;
    x_in  = W'(777);
    tick();
    start = 1'b0;
    guard = 0;
    while (ctl_log.size() < base + 2 && guard < 100) begin
      tick();
      guard++;
    end
    chk("mid_reached_lo", W'(ctl_log.size() - base), W'(2));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_ready", W'(ready), W'(1));
    chk("mid_mul_val", W'(mul_val_o), W'(0));
    chk("mid_val", W'(val), W'(0));
    chk("mid_err", W'(err), W'(0));
    chk("mid_ctl", W'(ctl), W'(2));
    hold_x = W'(424242);
    exp_x  = mont_ref(mont_ref(mont_ref(hold_x, m, mp), m, mp), m, mp);
    base   = ctl_log.size();
    run(32'd3, hold_x, cycles);
    chk("post_rst_x", xo, exp_x);
    chk("post_rst_latency", W'(cycles), W'(46));
    chk_ctl("post_rst", base, 9);
    accept();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/redun_mont_sq_sequencer.md
Name: redun_mont_sq_sequencer

Overview:
- Sequences one multi-mode multiplier instance through repeated Montgomery squarings of a redundant-form value x.
- Each iteration issues three operations in order: square (ctl=2), low multiply by M' (ctl=0), then high multiply by M with add term (ctl=1).
- Sits between the VDF top-level (start/result handshake) and the multiplier datapath. Owns the iteration counter and the intermediate T/Q registers.

Parameters:
- NUM_ELEMENTS, 33, limbs per operand.
- DSP_BIT_LEN, 17, bits per limb.
- ITER_W, 32, width of the iteration count.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  start request; accepted when o_ready=1
- o_ready  out  1  idle, can accept start
- i_iter  in  ITER_W  number of squarings, sampled at start
- i_x  in  NUM_ELEMENTS x DSP_BIT_LEN  initial value, sampled at start
- i_m  in  NUM_ELEMENTS x DSP_BIT_LEN  modulus M, static during a run
- i_mprime  in  NUM_ELEMENTS x DSP_BIT_LEN  M' = -M^-1 mod R, static during a run
- o_mul_val  out  1  one-cycle issue strobe to the multiplier
- o_mul_ctl  out  2  0=low, 1=high, 2=square
- o_mul_a / o_mul_b / o_mul_add  out  NUM_ELEMENTS x DSP_BIT_LEN  operands and add term
- i_mul_val  in  1  multiplier result valid
- i_mul_dat  in  2*NUM_ELEMENTS x DSP_BIT_LEN  multiplier product
- o_val  out  1  result valid; held until accepted
- i_rdy  in  1  result accept
- o_x  out  NUM_ELEMENTS x DSP_BIT_LEN  final value
- o_err  out  1  sticky protocol error
- o_cycle_cnt  out  32  see Optional Feature

Behaviour:
- Reset values: o_ready=1, o_val=0, o_mul_val=0, o_mul_ctl=2, o_err=0, o_cycle_cnt=0. All data outputs and internal registers are 0. FSM enters IDLE.
- FSM states: IDLE, ISS_SQ, WT_SQ, ISS_LO, WT_LO, ISS_HI, WT_HI, DONE.
- IDLE: when i_start=1, latch i_x into X and i_iter into CNT.
  - If i_iter=0: go to DONE; o_x=i_x.
  - Otherwise: go to ISS_SQ.
- ISS_SQ: o_mul_val=1, ctl=2, a=b=X, add=0. Next state WT_SQ.
- WT_SQ: on i_mul_val, capture TL = dat[0..N-1] and TH = dat[N..2N-1]. Next state ISS_LO.
- ISS_LO: o_mul_val=1, ctl=0, a=TL, b=i_mprime, add=0. Next state WT_LO.
- WT_LO: on i_mul_val, capture Q = dat[0..N-1]. Next state ISS_HI.
- ISS_HI: o_mul_val=1, ctl=1, a=Q, b=i_m, add=TH in natural limb order (the multiplier reverses it internally). Next state WT_HI.
- WT_HI: on i_mul_val, X = dat[N..2N-1] and CNT decrements.
  - CNT reaching 0 -> DONE.
  - Otherwise -> ISS_SQ.
- DONE: o_val=1 and o_x=X. On i_rdy=1, drop o_val and go to IDLE.
- o_ready is 1 only in IDLE. i_start in any other state is ignored.
- Exactly one multiplier operation is in flight at a time. The ctl order is always 2,0,1 so it stays aligned with a multiplier built with fixed internal ctl cycling. The sequencer never aborts mid-iteration.
- o_mul_val is high for exactly one cycle per issue. Operands and ctl are registered and held stable until the next issue.
- i_mul_val outside a WT_* state is ignored and sets o_err. o_err clears only on reset.
- Minimum turnaround: 1 cycle from i_mul_val to the next issue.
- Iteration latency = 3*(L+1) cycles, where L is the multiplier latency from issue to valid.
- Reset mid-run: returns to IDLE immediately. The multiplier must be reset on the same i_rst.

Optional Feature:
- Macro: REDUN_MONT_SEQ_CYCLE_CNT_EN.
- Defined: o_cycle_cnt clears on an accepted start, increments every cycle outside IDLE/DONE (saturating at 2^32-1), and holds in DONE.
- Undefined: o_cycle_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Package redun_mont_pkg holds:
  - the ctl encoding constants (CTL_LO=0, CTL_HI=1, CTL_SQ=2);
  - the FSM state enum;
  - the limb-array typedef.
- No sub-module. The limb half-select/capture logic stays inline.

Test Plan:
- i_iter=0, i_x=5 -> o_val one cycle after start, o_x=5, zero issues observed.
- i_iter=1, small M=0x7, x=3, bench multiplier model with L=4 -> issues ctl sequence 2,0,1. o_val asserts at cycle 16±1. o_x matches the software Montgomery square (congruent mod M).
- i_iter=10, random 33-limb x/M -> 30 issues with ctl repeating 2,0,1. o_x matches the reference model. o_cycle_cnt=30*(L+1) with the macro defined, 0 without.
- Hold i_rdy=0 for 20 cycles in DONE -> o_val and o_x stable. i_start pulses during that window are ignored; o_ready=0.
- Inject i_mul_val while in IDLE -> o_err=1 and stays 1; a subsequent normal run still completes correctly.
- Assert i_rst during WT_LO -> next cycle o_ready=1, o_mul_val=0, o_val=0. A new run then completes correctly.
